shift_mult_dispatcher: RTL

Operand-dispatch and result-collection stage placed directly upstream of the serial shift-add multiplier. It accepts operand pairs on a valid/ready stream and buffers them in a small FIFO. Each pair is issued to the multiplier with a one-cycle start pulse, and each product is returned on a valid/ready output stream. This hides the multiplier's multi-cycle busy period from producers and consumers.

---
 rtl/shift_mult_pkg.sv | 22 ++
 rtl/op_fifo.sv | 68 ++++++
 rtl/shift_mult_dispatcher.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/shift_mult_pkg.sv
// Shared definitions for the shift-add multiplier dispatch stage.
//   DEFAULT_DATA_WIDTH  : default operand width
//   DEFAULT_PROD_WIDTH  : default product width (twice the operand width)
//   state_t             : dispatcher FSM states IDLE/ISSUE/WAIT/OUT
//   prod_width()        : product width for a given operand width
package shift_mult_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_PROD_WIDTH = 2 * DEFAULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic int prod_width(input int data_width);
    return 2 * data_width;
  endfunction

endpackage

// File: rtl/op_fifo.sv
// Synchronous operand FIFO holding packed {a,b} pairs.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset (pointers/count)
//   push, wdata     : write request and data; ignored while full
//   pop, rdata      : read request; rdata always shows the head entry
//   full, empty     : occupancy flags
//   count           : number of stored entries (0..DEPTH)
// DEPTH must be a power of two so the pointers wrap naturally.
module op_fifo
  import shift_mult_pkg::*;
#(
  parameter int WIDTH = 2 * DEFAULT_DATA_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Storage is not reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Simultaneous push and pop move both pointers and leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_mult_dispatcher.sv
// Operand dispatch / result collection in front of a serial shift-add
// multiplier. Operand pairs are buffered in a FIFO, issued one at a time
// with a single-cycle start pulse, and products are returned on a
// valid/ready stream. Only one product is in flight; order is strict FIFO.
// Ports:
//   clk, rst_n              : clock, asynchronous active-low reset
//   s_valid/s_ready/s_a/s_b : operand input stream
//   m_valid/m_ready/m_result: product output stream
//   mul_valid, mul_a, mul_b : start pulse and held operands to multiplier
//   mul_busy, mul_done,
//   mul_result              : multiplier status and product
//   pending                 : FIFO occupancy
//   timeout_err             : sticky watchdog flag
// Optional feature: define MUL_TIMEOUT_EN to enable the WAIT watchdog;
// without it WAIT lasts until mul_done and timeout_err is tied low.
module shift_mult_dispatcher
  import shift_mult_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_a,
  input  logic [DATA_WIDTH-1:0]         s_b,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [2*DATA_WIDTH-1:0]       m_result,
  output logic                          mul_valid,
  output logic [DATA_WIDTH-1:0]         mul_a,
  output logic [DATA_WIDTH-1:0]         mul_b,
  input  logic                          mul_busy,
  input  logic                          mul_done,
  input  logic [2*DATA_WIDTH-1:0]       mul_result,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          timeout_err
);

  localparam int PW = prod_width(DATA_WIDTH);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  state_t                state;
  state_t                state_n;
  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [PW-1:0]         fifo_rdata;
  logic                  timeout_hit;

  op_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .wdata ({s_a, s_b}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  assign s_ready = !fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // A new pair is popped only when the multiplier reports idle; mul_valid
  // is a pure decode of ISSUE so it is exactly one cycle wide.
  always_comb begin
    state_n   = state;
    fifo_pop  = 1'b0;
    mul_valid = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !mul_busy) begin
          fifo_pop = 1'b1;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        mul_valid = 1'b1;
        state_n   = WAIT;
      end
      WAIT: begin
        if (mul_done || timeout_hit) begin
          state_n = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Operands stay on mul_a/mul_b until the next pop; the product register
  // only loads in WAIT, so stray mul_done pulses elsewhere are ignored.
  // A real mul_done wins over a watchdog expiry in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      m_result <= PW'(0);
      m_valid  <= 1'b0;
    end else begin
      if (fifo_pop) begin
        {mul_a, mul_b} <= fifo_rdata;
      end
      if (state == WAIT && mul_done) begin
        m_result <= mul_result;
        m_valid  <= 1'b1;
      end else if (timeout_hit) begin
        m_result <= PW'(0);
        m_valid  <= 1'b1;
      end else if (state == OUT && m_ready) begin
        m_valid  <= 1'b0;
      end
    end
  end

`ifdef MUL_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT) + 1;

  logic [WDW-1:0] wd_cnt;

  // wd_cnt is the number of WAIT cycles already spent, so the hit fires on
  // the TIMEOUT-th WAIT cycle without a completion.
  assign timeout_hit = (state == WAIT) && !mul_done && (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == WAIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
      if (timeout_hit) begin
        timeout_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
